// File: rtl/jk_ff_bank.sv
`default_nettype none
// ============================================================================
//  Module      : jk_ff_bank
//  Description : Bank of WIDTH independent JK flip-flops with parallel load,
//                per-edge change mask and a saturating change-event counter.
//                Edge priority is rst > load > en > hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_ff_bank #(
    parameter int                WIDTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}},
    parameter int                CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  d,
    input  logic [WIDTH-1:0]  j,
    input  logic [WIDTH-1:0]  k,
    input  logic              clr_cnt,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qn,
    output logic [WIDTH-1:0]  chg,
    output logic [CNT_W-1:0]  chg_cnt,
    output logic              cnt_sat
);

    // Counter saturation ceiling (all ones) and unit increment.
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_ZERO = {CNT_W{1'b0}};

    // Registered state and its next-state values.
    logic [WIDTH-1:0] r_state_q;
    logic [WIDTH-1:0] w_state_d;
    logic [WIDTH-1:0] r_chg_q;
    logic [WIDTH-1:0] w_chg_d;
    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    // Helper wires.
    logic [WIDTH-1:0] w_jk_next;
    logic             w_any_change;
    logic             w_cnt_at_max;

    // Per-channel JK characteristic: 00 hold, 01 clear, 10 set, 11 toggle.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
            assign w_jk_next[gi] = (j[gi] & ~r_state_q[gi]) |
                                   (~k[gi] & r_state_q[gi]);
        end
    endgenerate

    assign w_cnt_at_max = (r_cnt_q == c_CNT_MAX);

    // Next state of q, the change mask and the event counter.
    always_comb begin
        w_state_d = r_state_q;
        if (load) begin
            w_state_d = d;
        end else if (en) begin
            w_state_d = w_jk_next;
        end

        // A reload of the same value or a held state yields an all-zero mask.
        w_chg_d      = w_state_d ^ r_state_q;
        w_any_change = |w_chg_d;

        // Clear beats increment; any number of changed bits is one event.
        w_cnt_d = r_cnt_q;
        if (clr_cnt) begin
            w_cnt_d = c_CNT_ZERO;
        end else if (w_any_change && !w_cnt_at_max) begin
            w_cnt_d = r_cnt_q + c_CNT_ONE;
        end
    end

    // State registers; reset overrides load, en and clr_cnt and is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= RST_VAL;
            r_chg_q   <= {WIDTH{1'b0}};
            r_cnt_q   <= c_CNT_ZERO;
        end else begin
            r_state_q <= w_state_d;
            r_chg_q   <= w_chg_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign q       = r_state_q;
    assign qn      = ~r_state_q;
    assign chg     = r_chg_q;
    assign chg_cnt = r_cnt_q;
    assign cnt_sat = w_cnt_at_max;

endmodule
`default_nettype wire

// File: tb/tb_jk_ff_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_ff_bank
//  Description : Self-checking bench for jk_ff_bank (WIDTH=4, CNT_W=3).
//                Table-driven vectors feed an expected-value queue that is
//                popped and compared after each clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_ff_bank;

    localparam int W  = 4;
    localparam int CW = 3;

    logic          clk;
    logic          rst;
    logic          en;
    logic          load;
    logic [W-1:0]  d;
    logic [W-1:0]  j;
    logic [W-1:0]  k;
    logic          clr_cnt;
    logic [W-1:0]  q;
    logic [W-1:0]  qn;
    logic [W-1:0]  chg;
    logic [CW-1:0] chg_cnt;
    logic          cnt_sat;

    jk_ff_bank #(
        .WIDTH   (W),
        .RST_VAL (4'b0000),
        .CNT_W   (CW)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .d       (d),
        .j       (j),
        .k       (k),
        .clr_cnt (clr_cnt),
        .q       (q),
        .qn      (qn),
        .chg     (chg),
        .chg_cnt (chg_cnt),
        .cnt_sat (cnt_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          load;
        logic          en;
        logic          clr;
        logic [W-1:0]  d;
        logic [W-1:0]  j;
        logic [W-1:0]  k;
        logic [W-1:0]  eq;
        logic [W-1:0]  echg;
        logic [CW-1:0] ecnt;
        logic          esat;
    } vec_t;

    typedef struct {
        logic [W-1:0]  eq;
        logic [W-1:0]  echg;
        logic [CW-1:0] ecnt;
        logic          esat;
        int            tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(logic r, logic l, logic e, logic c,
                                logic [W-1:0] dd, logic [W-1:0] jj, logic [W-1:0] kk,
                                logic [W-1:0] eq, logic [W-1:0] ec,
                                logic [CW-1:0] en_cnt, logic es);
        vec_t v;
        v.rst = r; v.load = l; v.en = e; v.clr = c;
        v.d = dd; v.j = jj; v.k = kk;
        v.eq = eq; v.echg = ec; v.ecnt = en_cnt; v.esat = es;
        return v;
    endfunction

    task automatic chk(string name, int tag, logic [7:0] act, logic [7:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s (step %0d): got %b, expected %b", name, tag, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(vec_t v, int tag);
        exp_t e;
        exp_t got;
        rst = v.rst; load = v.load; en = v.en; clr_cnt = v.clr;
        d = v.d; j = v.j; k = v.k;
        e.eq = v.eq; e.echg = v.echg; e.ecnt = v.ecnt; e.esat = v.esat; e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL scoreboard (step %0d): queue empty, got 1 expected 0", tag);
        end else begin
            got = sb_q.pop_front();
            chk("q",       got.tag, {4'b0, q},       {4'b0, got.eq});
            chk("qn",      got.tag, {4'b0, qn},      {4'b0, ~got.eq});
            chk("chg",     got.tag, {4'b0, chg},     {4'b0, got.echg});
            chk("chg_cnt", got.tag, {5'b0, chg_cnt}, {5'b0, got.ecnt});
            chk("cnt_sat", got.tag, {7'b0, cnt_sat}, {7'b0, got.esat});
        end
    endtask

    vec_t vecs[16];

    initial begin
        rst = 1'b1; load = 1'b0; en = 1'b0; clr_cnt = 1'b0;
        d = '0; j = '0; k = '0;
        #2;

        //             rst load en clr d        j        k        q        chg      cnt   sat
        vecs[0]  = mk(1, 1, 1, 1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 3'd0, 0);
        vecs[1]  = mk(0, 0, 1, 0, 4'b0000, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 3'd1, 0);
        vecs[2]  = mk(0, 0, 1, 0, 4'b0000, 4'b1111, 4'b1111, 4'b0101, 4'b1111, 3'd2, 0);
        vecs[3]  = mk(0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0101, 4'b0000, 4'b0101, 3'd3, 0);
        vecs[4]  = mk(0, 1, 1, 0, 4'b0110, 4'b1111, 4'b1111, 4'b0110, 4'b0110, 3'd4, 0);
        vecs[5]  = mk(0, 1, 0, 0, 4'b0110, 4'b0000, 4'b0000, 4'b0110, 4'b0000, 3'd4, 0);
        vecs[6]  = mk(0, 0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 4'b0110, 4'b0000, 3'd4, 0);
        vecs[7]  = mk(0, 0, 1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b0000, 3'd4, 0);
        vecs[8]  = mk(0, 0, 1, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0111, 4'b0001, 3'd5, 0);
        vecs[9]  = mk(0, 0, 1, 1, 4'b0000, 4'b1111, 4'b1111, 4'b1000, 4'b1111, 3'd0, 0);
        vecs[10] = mk(0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 3'd0, 0);
        vecs[11] = mk(0, 1, 0, 0, 4'b1100, 4'b0000, 4'b0000, 4'b1100, 4'b0100, 3'd1, 0);
        vecs[12] = mk(1, 1, 1, 1, 4'b0011, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 3'd0, 0);
        vecs[13] = mk(0, 0, 0, 0, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 3'd0, 0);
        vecs[14] = mk(0, 0, 1, 0, 4'b0000, 4'b0011, 4'b1100, 4'b0011, 4'b0011, 3'd1, 0);
        vecs[15] = mk(0, 0, 1, 0, 4'b0000, 4'b1111, 4'b1111, 4'b1100, 4'b1111, 3'd2, 0);

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i], i);
        end

        // Saturation: reset, then toggle every bit for ten edges.
        apply(mk(1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3'd0, 0), 100);
        for (int n = 1; n <= 10; n++) begin
            apply(mk(0, 0, 1, 0, 4'b0000, 4'b1111, 4'b1111,
                     (n % 2 == 1) ? 4'b1111 : 4'b0000, 4'b1111,
                     (n >= 7) ? 3'd7 : 3'(n), (n >= 7)), 100 + n);
        end
        // Saturated counter stays put on a further change, then clears.
        apply(mk(0, 1, 0, 0, 4'b1001, 4'b0000, 4'b0000, 4'b1001, 4'b1001, 3'd7, 1), 111);
        apply(mk(0, 0, 0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 3'd0, 0), 112);

        // Reset mid-toggle leaves no residual change pulse.
        apply(mk(0, 0, 1, 0, 4'b0000, 4'b1111, 4'b1111, 4'b0110, 4'b1111, 3'd1, 0), 120);
        apply(mk(1, 0, 1, 0, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 3'd0, 0), 121);
        apply(mk(0, 0, 0, 0, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 3'd0, 0), 122);

        // qn follows q with no extra cycle.
        n_total++;
        if (qn === ~q) n_pass++;
        else $display("FAIL qn_comb: got %b, expected %b", qn, ~q);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/jk_ff_bank.md
JK_FF_BANK -- requirements
Module: jk_ff_bank

Interface
REQ-001 Parameter WIDTH, default 4: number of independent JK channels, at least 1.
REQ-002 Parameter RST_VAL, default {WIDTH{1'b0}}: value loaded into q by reset.
REQ-003 Parameter CNT_W, default 8: width of the change-event counter, at least 2.
REQ-004 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port en  input  1: JK update enable.
REQ-007 Port load  input  1: parallel-load strobe.
REQ-008 Port d  input  WIDTH: parallel-load data.
REQ-009 Port j  input  WIDTH: per-channel J inputs.
REQ-010 Port k  input  WIDTH: per-channel K inputs.
REQ-011 Port clr_cnt  input  1: synchronous clear of the change counter.
REQ-012 Port q  output  WIDTH: registered channel state.
REQ-013 Port qn  output  WIDTH: combinational complement of q.
REQ-014 Port chg  output  WIDTH: registered mask of the bits that changed at the previous edge.
REQ-015 Port chg_cnt  output  CNT_W: saturating count of edges at which q changed.
REQ-016 Port cnt_sat  output  1: high while chg_cnt equals 2^CNT_W-1.

Function
REQ-017 Update priority on each rising edge SHALL be rst > load > en > hold.
REQ-018 With load=1 and rst=0, q SHALL take d on the next edge, regardless of en, j and k.
REQ-019 With en=1, load=0 and rst=0, each bit i SHALL update independently: j=0,k=0 hold; j=0,k=1 clear; j=1,k=0 set; j=1,k=1 toggle.
REQ-020 With en=0, load=0 and rst=0, q SHALL hold and j and k SHALL be ignored.
REQ-021 qn SHALL equal ~q at all times, with zero cycles of latency.
REQ-022 At each non-reset edge, chg SHALL be loaded with q_next XOR q_current, so each chg bit is valid for exactly one cycle after the edge that changed that bit.
REQ-023 chg SHALL be all zeros after any edge at which q does not change.
REQ-024 chg_cnt SHALL increment by 1 at each non-reset edge where q_next differs from q_current in any bit, independent of how many bits change.
REQ-025 chg_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-026 clr_cnt=1 SHALL set chg_cnt to 0 on the next edge and SHALL win over a simultaneous increment; it SHALL NOT affect q or chg.
REQ-027 cnt_sat SHALL be derived combinationally from chg_cnt.
REQ-028 A load of a value equal to the current q SHALL produce chg=0 and no count.
REQ-029 A JK toggle on every bit SHALL count as a single event.

Reset
REQ-030 rst=1 at an edge SHALL set q=RST_VAL, chg=0, chg_cnt=0 and cnt_sat=0, overriding load, en and clr_cnt.
REQ-031 The reset edge SHALL NOT be counted as a change event, even if q differs from RST_VAL.
REQ-032 Asserting rst mid-operation SHALL take effect at the next edge with no residual chg pulse afterward.
REQ-033 Before the first reset, output values are unspecified; the bench SHALL reset first.

Verification (WIDTH=4, RST_VAL=4'b0000, CNT_W=3 unless stated)
REQ-034 Reset, then en=1 with j=4'b1010, k=4'b0000 -> q=4'b1010, qn=4'b0101, chg=4'b1010 next cycle, chg_cnt=1.
REQ-035 From q=4'b1010, apply j=4'b1111, k=4'b1111 for 1 cycle, then j=4'b0000, k=4'b0101 -> q=4'b0101 then 4'b0000; chg=4'b1111 then 4'b0101; chg_cnt goes from 1 to 2 to 3.
REQ-036 From q=4'b0000, apply load=1, d=4'b0110, en=1, j=k=4'b1111 -> q=4'b0110, since load wins; then load 4'b0110 again -> chg=0 and chg_cnt unchanged.
REQ-037 Toggle all bits for 10 consecutive edges from reset -> chg_cnt reaches 7 and holds, cnt_sat=1 from the 7th edge, q=4'b0000 after the 10 edges.
REQ-038 With chg_cnt=5, assert clr_cnt together with a toggle -> q toggles, chg=4'b1111, chg_cnt=0.
REQ-039 With q=4'b1100, assert rst with load=1, d=4'b0011 -> q=4'b0000, chg=0, chg_cnt=0; en=0 on the next cycle -> q holds and chg=0.
